prbs_checker: RTL and testbench
===============================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 4: consecutive matching samples required to declare lock.
REQ-002 The block SHALL have parameter LOSS_CNT, default 3: consecutive mismatching samples that drop lock.
REQ-003 The block SHALL have port `clk`: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port `rst`: input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port `enable`: input, 1 bit; when high, `data_in` holds a valid PRBS word this cycle.
REQ-006 The block SHALL have port `data_in`: input, 4 bits; the PRBS word from the upstream pseudo_random_generator `prbs_out`.
REQ-007 The block SHALL have port `locked`: output, 1 bit; checker is synchronised to the incoming sequence.
REQ-008 The block SHALL have port `error`: output, 1 bit; one-cycle pulse on a mismatch while locked.
REQ-009 The block SHALL have port `err_count`: output, 8 bits; saturating count of mismatches seen while locked.
REQ-010 The block SHALL have port `zero_stuck`: output, 1 bit; the last enabled sample was 4'b0000, an illegal LFSR state.

Function
REQ-011 The LFSR step SHALL be next(q) = {q[2:0], q[3]^q[2]} (x^4+x^3+1, period 15), identical to the upstream generator.
REQ-012 The block SHALL implement states IDLE, ACQUIRE and LOCKED, plus a 4-bit expected register `exp`, a match-run counter and a miss-run counter.
REQ-013 When `enable` is low, all state, counters, `exp`, `locked`, `err_count` and `zero_stuck` SHALL hold, and `error` SHALL be 0.
REQ-014 In IDLE, an enabled sample equal to 0 SHALL set `zero_stuck`=1 and stay in IDLE; a non-zero sample SHALL clear `zero_stuck`, load `exp`<=next(data_in), clear match-run and go to ACQUIRE.
REQ-015 In ACQUIRE, an enabled sample equal to `exp` SHALL advance `exp`<=next(exp) and increment match-run.
REQ-016 In ACQUIRE, when a match brings match-run to LOCK_CNT, the block SHALL go to LOCKED with `locked`=1 and miss-run=0.
REQ-017 In ACQUIRE, an enabled non-zero mismatch SHALL re-seed `exp`<=next(data_in), clear match-run and stay in ACQUIRE.
REQ-018 In ACQUIRE, an enabled zero sample SHALL set `zero_stuck`=1 and go to IDLE.
REQ-019 In LOCKED, `exp`<=next(exp) SHALL occur on every enabled sample, regardless of match (flywheel).
REQ-020 In LOCKED, a match SHALL clear miss-run.
REQ-021 In LOCKED, a mismatch SHALL pulse `error`=1 for exactly that cycle, increment `err_count` (saturating at 255) and increment miss-run.
REQ-022 In LOCKED, when a mismatch brings miss-run to LOSS_CNT, the block SHALL go to ACQUIRE with `locked`=0, match-run=0, `exp`<=next(data_in); that mismatch SHALL still be counted.
REQ-023 In LOCKED, a zero sample SHALL be treated as a mismatch and SHALL also set `zero_stuck`=1; any non-zero enabled sample SHALL clear `zero_stuck`.
REQ-024 All outputs SHALL be registered, and the response to a sample taken at edge N SHALL be visible after edge N (one-cycle latency).
REQ-025 `err_count` at 255 SHALL stay 255 on further mismatches, with `error` still pulsing.
REQ-026 Mismatches in IDLE or ACQUIRE SHALL NOT pulse `error` or change `err_count`.

Reset
REQ-027 While `rst`=1 at a clock edge, the block SHALL set state=IDLE, `exp`=0, both run counters=0, `locked`=0, `error`=0, `err_count`=0 and `zero_stuck`=0; `rst` SHALL have priority over `enable`.
REQ-028 A reset asserted mid-operation, including while LOCKED, SHALL take effect at the next edge and discard all accumulated state.

Verification
REQ-029 The bench SHALL check acquisition: reset, then enabled samples 1010,0101,1011,0111,1111 -> `locked`=1 after the 5th sample, `err_count`=0, `error` never high.
REQ-030 The bench SHALL check a single error: locked on the 1010 sequence, inject 0000 in place of 1110, then resume with 1100 -> one `error` pulse, `err_count`=1, `zero_stuck` pulses high then clears, `locked` stays 1.
REQ-031 The bench SHALL check loss of lock: locked, then 3 consecutive wrong words -> 3 `error` pulses, `err_count`=3, `locked`=0 after the 3rd; correct sequence resumes -> relock after 5 samples.
REQ-032 The bench SHALL check enable gating: locked, `enable` low for 10 cycles with `data_in` random -> no state change, `error`=0; re-enable with the next in-sequence word -> no error.
REQ-033 The bench SHALL check saturation: force 300 mismatches while locked with LOSS_CNT=1000 override -> `err_count`=255.
REQ-034 The bench SHALL check mid-run reset: `rst` pulsed for 1 cycle while locked with `err_count`=2 -> all outputs 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/prbs_checker.sv
// PRBS checker for the x^4+x^3+1 sequence: acquires lock on a run of predicted
// words, then flywheels and counts mismatches until too many in a row drop lock.
module prbs_checker #(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [3:0] data_in,
   output logic       locked,
   output logic       error,
   output logic [7:0] err_count,
   output logic       zero_stuck
);

   localparam int MW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
   localparam int LW = (LOSS_CNT < 1) ? 1 : $clog2(LOSS_CNT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      exp_q, exp_d;
   logic [MW-1:0]   match_run_q, match_run_d;
   logic [LW-1:0]   miss_run_q, miss_run_d;
   logic            locked_q, locked_d;
   logic            error_q, error_d;
   logic [7:0]      err_count_q, err_count_d;
   logic            zero_stuck_q, zero_stuck_d;

   logic            sample_zero;
   logic            sample_match;

   function automatic logic [3:0] lfsr_next(input logic [3:0] q);
      return {q[2:0], q[3] ^ q[2]};
   endfunction

   assign sample_zero  = (data_in == 4'd0);
   assign sample_match = (data_in == exp_q);

   always_comb begin
      state_d      = state_q;
      exp_d        = exp_q;
      match_run_d  = match_run_q;
      miss_run_d   = miss_run_q;
      locked_d     = locked_q;
      error_d      = 1'b0;
      err_count_d  = err_count_q;
      zero_stuck_d = zero_stuck_q;

      if (enable) begin
         zero_stuck_d = sample_zero;
         case (state_q)
            IDLE: begin
               if (!sample_zero) begin
                  exp_d       = lfsr_next(data_in);
                  match_run_d = '0;
                  state_d     = ACQUIRE;
               end
            end

            ACQUIRE: begin
               if (sample_zero) begin
                  state_d = IDLE;
               end else if (sample_match) begin
                  exp_d       = lfsr_next(exp_q);
                  match_run_d = match_run_q + MW'(1);
                  if (match_run_q == MW'(LOCK_CNT - 1)) begin
                     state_d    = LOCKED;
                     locked_d   = 1'b1;
                     miss_run_d = '0;
                  end
               end else begin
                  // Re-seed from the observed word so a phase slip recovers quickly
                  exp_d       = lfsr_next(data_in);
                  match_run_d = '0;
               end
            end

            LOCKED: begin
               exp_d = lfsr_next(exp_q);
               if (sample_match) begin
                  miss_run_d = '0;
               end else begin
                  error_d = 1'b1;
                  if (err_count_q != 8'hFF) begin
                     err_count_d = err_count_q + 8'd1;
                  end
                  if (miss_run_q == LW'(LOSS_CNT - 1)) begin
                     state_d     = ACQUIRE;
                     locked_d    = 1'b0;
                     match_run_d = '0;
                     exp_d       = lfsr_next(data_in);
                  end else begin
                     miss_run_d = miss_run_q + LW'(1);
                  end
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         exp_q        <= 4'd0;
         match_run_q  <= '0;
         miss_run_q   <= '0;
         locked_q     <= 1'b0;
         error_q      <= 1'b0;
         err_count_q  <= 8'd0;
         zero_stuck_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         match_run_q  <= match_run_d;
         miss_run_q   <= miss_run_d;
         locked_q     <= locked_d;
         error_q      <= error_d;
         err_count_q  <= err_count_d;
         zero_stuck_q <= zero_stuck_d;
      end
   end

   assign locked     = locked_q;
   assign error      = error_q;
   assign err_count  = err_count_q;
   assign zero_stuck = zero_stuck_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed and randomized checks of prbs_checker against a sample-by-sample model;
// instance 1 uses a very large loss threshold to exercise counter saturation.
module tb_prbs_checker;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      en;
   logic [1:0][3:0] din;
   logic [1:0]      locked;
   logic [1:0]      error;
   logic [1:0][7:0] err_count;
   logic [1:0]      zero_stuck;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prbs_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) u_dut (
      .clk(clk), .rst(rst), .enable(en[0]), .data_in(din[0]),
      .locked(locked[0]), .error(error[0]), .err_count(err_count[0]),
      .zero_stuck(zero_stuck[0])
   );

   prbs_checker #(.LOCK_CNT(4), .LOSS_CNT(1000)) u_sat (
      .clk(clk), .rst(rst), .enable(en[1]), .data_in(din[1]),
      .locked(locked[1]), .error(error[1]), .err_count(err_count[1]),
      .zero_stuck(zero_stuck[1])
   );

   // Reference model: 0 = searching, 1 = acquiring, 2 = synchronised
   int         m_mode  [2];
   logic [3:0] m_exp   [2];
   int         m_match [2];
   int         m_miss  [2];
   int         m_cnt   [2];
   bit         m_lock  [2];
   bit         m_err   [2];
   bit         m_zs    [2];
   int         m_loss  [2] = '{3, 1000};
   localparam int M_LOCK = 4;

   function automatic logic [3:0] nxt(input logic [3:0] q);
      return {q[2:0], q[3] ^ q[2]};
   endfunction

   function automatic logic [3:0] wrong_word(input logic [3:0] e, input bit allow_zero);
      logic [3:0] w;
      do w = 4'($urandom_range(allow_zero ? 0 : 1, 15)); while (w == e);
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = 0; m_exp[i] = 4'd0; m_match[i] = 0; m_miss[i] = 0;
         m_cnt[i] = 0; m_lock[i] = 0; m_err[i] = 0; m_zs[i] = 0;
      end
   endtask

   task automatic model_step(input int i, input bit e, input logic [3:0] d);
      m_err[i] = 0;
      if (!e) return;
      m_zs[i] = (d == 4'd0);
      if (m_mode[i] == 0) begin
         if (d != 0) begin m_exp[i] = nxt(d); m_match[i] = 0; m_mode[i] = 1; end
      end else if (m_mode[i] == 1) begin
         if (d == 0) m_mode[i] = 0;
         else if (d == m_exp[i]) begin
            m_exp[i] = nxt(m_exp[i]);
            m_match[i]++;
            if (m_match[i] == M_LOCK) begin m_mode[i] = 2; m_lock[i] = 1; m_miss[i] = 0; end
         end else begin
            m_exp[i] = nxt(d); m_match[i] = 0;
         end
      end else begin
         if (d == m_exp[i]) begin
            m_miss[i] = 0; m_exp[i] = nxt(m_exp[i]);
         end else begin
            m_err[i] = 1;
            m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
            m_miss[i]++;
            if (m_miss[i] == m_loss[i]) begin
               m_mode[i] = 1; m_lock[i] = 0; m_match[i] = 0; m_exp[i] = nxt(d);
            end else begin
               m_exp[i] = nxt(m_exp[i]);
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string ctx);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s[%0d].locked", ctx, i), 32'(locked[i]), 32'(m_lock[i]));
         chk($sformatf("%s[%0d].error", ctx, i), 32'(error[i]), 32'(m_err[i]));
         chk($sformatf("%s[%0d].err_count", ctx, i), 32'(err_count[i]), 32'(m_cnt[i]));
         chk($sformatf("%s[%0d].zero_stuck", ctx, i), 32'(zero_stuck[i]), 32'(m_zs[i]));
      end
   endtask

   task automatic step(input string ctx, input int i, input bit e, input logic [3:0] d);
      en     = 2'b00;
      en[i]  = e;
      din[i] = d;
      @(posedge clk);
      #1;
      model_step(0, en[0], din[0]);
      model_step(1, en[1], din[1]);
      check_all(ctx);
      $display("step %-8s inst=%0d en=%0b din=%b -> locked=%0b error=%0b err_count=%0d zero_stuck=%0b",
               ctx, i, e, d, locked[i], error[i], err_count[i], zero_stuck[i]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 2'b11;
      din[0] = 4'b1010;
      din[1] = 4'b1010;
      @(posedge clk);
      #1;
      rst = 1'b0;
      en  = 2'b00;
      model_reset();
      check_all("reset");
      $display("reset -> locked=%b error=%b err_count=%0d/%0d zero_stuck=%b",
               locked, error, err_count[0], err_count[1], zero_stuck);
   endtask

   task automatic acquire(input string ctx, input int i, input logic [3:0] seed);
      logic [3:0] w;
      w = seed;
      for (int k = 0; k < 5; k++) begin
         step(ctx, i, 1'b1, w);
         w = nxt(w);
      end
   endtask

   initial begin
      logic [3:0] w;
      int         err_seen;
      rst = 1'b0;
      en  = 2'b00;
      din = '0;
      model_reset();
      @(posedge clk);
      #1;

      // Reset state
      do_reset();
      chk("reset_locked", 32'(locked[0]), 32'd0);
      chk("reset_err_count", 32'(err_count[0]), 32'd0);

      // Acquisition on 1010,0101,1011,0111,1111
      err_seen = 0;
      w = 4'b1010;
      for (int k = 0; k < 5; k++) begin
         step("acq", 0, 1'b1, w);
         if (k == 3) chk("acq_not_yet_locked", 32'(locked[0]), 32'd0);
         err_seen += int'(error[0]);
         w = nxt(w);
      end
      chk("acq_locked", 32'(locked[0]), 32'd1);
      chk("acq_err_count", 32'(err_count[0]), 32'd0);
      chk("acq_no_error", 32'(err_seen), 32'd0);

      // Single zero error in place of 1110, then resume with 1100
      step("zero", 0, 1'b1, 4'b0000);
      chk("zero_error", 32'(error[0]), 32'd1);
      chk("zero_stuck_set", 32'(zero_stuck[0]), 32'd1);
      chk("zero_locked", 32'(locked[0]), 32'd1);
      step("resume", 0, 1'b1, 4'b1100);
      chk("resume_error", 32'(error[0]), 32'd0);
      chk("resume_zero_stuck", 32'(zero_stuck[0]), 32'd0);
      chk("resume_err_count", 32'(err_count[0]), 32'd1);
      chk("resume_locked", 32'(locked[0]), 32'd1);

      // Loss of lock after three consecutive wrong words
      for (int k = 0; k < 3; k++) begin
         step("loss", 0, 1'b1, wrong_word(m_exp[0], 1'b0));
         chk("loss_error", 32'(error[0]), 32'd1);
      end
      chk("loss_err_count", 32'(err_count[0]), 32'd4);
      chk("loss_unlocked", 32'(locked[0]), 32'd0);

      // Relock from a fresh seed that does not continue the re-seeded prediction
      w = wrong_word(m_exp[0], 1'b0);
      for (int k = 0; k < 5; k++) begin
         step("relock", 0, 1'b1, w);
         if (k == 3) chk("relock_not_yet", 32'(locked[0]), 32'd0);
         w = nxt(w);
      end
      chk("relock_locked", 32'(locked[0]), 32'd1);

      // Enable gating with random data
      for (int k = 0; k < 10; k++) begin
         step("gated", 0, 1'b0, 4'($urandom_range(0, 15)));
      end
      step("reenable", 0, 1'b1, m_exp[0]);
      chk("reenable_error", 32'(error[0]), 32'd0);
      chk("reenable_locked", 32'(locked[0]), 32'd1);

      // Mid-run reset while locked with two counted errors
      do_reset();
      acquire("acq2", 0, 4'b1010);
      step("err1", 0, 1'b1, wrong_word(m_exp[0], 1'b0));
      step("ok", 0, 1'b1, m_exp[0]);
      step("err2", 0, 1'b1, wrong_word(m_exp[0], 1'b0));
      step("ok", 0, 1'b1, m_exp[0]);
      chk("pre_rst_err_count", 32'(err_count[0]), 32'd2);
      chk("pre_rst_locked", 32'(locked[0]), 32'd1);
      do_reset();
      chk("mid_rst_locked", 32'(locked[0]), 32'd0);
      chk("mid_rst_err_count", 32'(err_count[0]), 32'd0);
      chk("mid_rst_error", 32'(error[0]), 32'd0);
      chk("mid_rst_zero_stuck", 32'(zero_stuck[0]), 32'd0);
      step("post_rst", 0, 1'b1, 4'b0101);
      chk("post_rst_idle", 32'(locked[0]), 32'd0);

      // Saturation on the large-loss instance
      acquire("acq_sat", 1, 4'($urandom_range(1, 15)));
      chk("sat_locked", 32'(locked[1]), 32'd1);
      for (int k = 0; k < 300; k++) begin
         step("sat", 1, 1'b1, wrong_word(m_exp[1], 1'b1));
      end
      chk("sat_err_count", 32'(err_count[1]), 32'd255);
      chk("sat_error_pulse", 32'(error[1]), 32'd1);
      chk("sat_still_locked", 32'(locked[1]), 32'd1);

      // Randomized mix of in-sequence words, corruptions and idle cycles
      for (int k = 0; k < 400; k++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 15)      step("fuzz", 0, 1'b0, 4'($urandom_range(0, 15)));
         else if (r < 80) step("fuzz", 0, 1'b1, (m_exp[0] == 4'd0) ? 4'b1001 : m_exp[0]);
         else             step("fuzz", 0, 1'b1, 4'($urandom_range(0, 15)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
